// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: byte-lane writes, burst address checking, two-cycle ERROR response.
// Latency: OKAY completes WAIT_STATES+1 cycles after address acceptance; ERROR always takes 2 cycles.
// Backpressure: HREADYOUT low during wait states and ERR1; no address phase accepted while HREADY is low.
// Ports: HCLK/HRESETn clock and async active-low reset; HSEL/HADDR/HWRITE/HSIZE/HBURST/HTRANS address phase;
//        HWDATA write data (data phase); HREADY bus ready in; HREADYOUT/HRESP/HRDATA slave response.
module ahb_lite_sram_slave #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [1:0]            HTRANS,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);
  localparam int unsigned           BYTES  = DATA_WIDTH / 8;
  localparam int unsigned           BSZ    = $clog2(BYTES);
  localparam int unsigned           MAW    = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-1:0] REGION = ADDR_WIDTH'(DEPTH_WORDS * BYTES);
  localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);
  localparam logic [2:0]            WS     = 3'(WAIT_STATES);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                state, state_d;
  logic [2:0]            cnt, cnt_d;
  logic [MAW-1:0]        dp_idx;
  logic [BSZ-1:0]        dp_off;
  logic [2:0]            dp_size;
  logic                  dp_write;
  logic                  trk_vld;
  logic [ADDR_WIDTH-1:0] trk_addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic                  acc, err, seq, is_wrap, wr_now, rd_load;
  logic [ADDR_WIDTH-1:0] off, incr, size_mask, wrap_mask, nxt_addr;
  logic [MAW-1:0]        acc_idx, rd_idx;
  logic [BYTES-1:0]      be;
  logic [DATA_WIDTH-1:0] rd_word;

  // HREADYOUT is high exactly in the states that can take a new address phase.
  assign HREADYOUT = (state != S_WAIT) && (state != S_ERR1);
  assign HRESP     = (state == S_ERR1 || state == S_ERR2) ? 2'b01 : 2'b00;

  assign acc       = HSEL && HREADY && HTRANS[1] && HREADYOUT;
  assign seq       = (HTRANS == 2'b11);
  assign off       = HADDR - BASE_ADDR;
  assign acc_idx   = off[BSZ +: MAW];
  assign incr      = ONE << HSIZE;
  assign size_mask = incr - ONE;
  // Wrap window is beats*size bytes; WRAP4/8/16 encode log2(beats)-1 in HBURST[2:1].
  assign wrap_mask = (incr << ({1'b0, HBURST[2:1]} + 3'd1)) - ONE;
  assign is_wrap   = !HBURST[0] && (HBURST != 3'b000);
  assign nxt_addr  = is_wrap ? ((HADDR & ~wrap_mask) | ((HADDR + incr) & wrap_mask))
                             : (HADDR + incr);

  assign err = (HADDR < BASE_ADDR) || (off >= REGION) ||
               (HSIZE > 3'(BSZ)) || ((HADDR & size_mask) != '0) ||
               (seq && (!trk_vld || (HADDR != trk_addr)));

  assign wr_now = (state == S_DATA) && dp_write;
  assign be     = BYTES'((1 << (1 << dp_size)) - 1) << dp_off;

  // HRDATA is loaded on the edge entering DATA. With zero wait states that edge
  // also commits the previous write, so same-word bytes are forwarded from HWDATA.
  assign rd_idx  = (state == S_WAIT) ? dp_idx : acc_idx;
  assign rd_load = (state_d == S_DATA) && ((state == S_WAIT) ? !dp_write : !HWRITE);

  always_comb begin
    rd_word = mem[rd_idx];
    for (int b = 0; b < BYTES; b++) begin
      if (wr_now && be[b] && (dp_idx == rd_idx)) rd_word[8*b +: 8] = HWDATA[8*b +: 8];
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      S_WAIT: begin
        if (cnt == 3'd0) state_d = S_DATA;
        else             cnt_d   = cnt - 3'd1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d = S_IDLE;
        if (acc) begin
          if (err) begin
            state_d = S_ERR1;
          end else if (WS != 3'd0) begin
            state_d = S_WAIT;
            cnt_d   = WS - 3'd1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dp_idx   <= '0;
      dp_off   <= '0;
      dp_size  <= '0;
      dp_write <= 1'b0;
      trk_vld  <= 1'b0;
      trk_addr <= '0;
      HRDATA   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (acc) begin
        dp_idx   <= acc_idx;
        dp_off   <= off[BSZ-1:0];
        dp_size  <= HSIZE;
        dp_write <= HWRITE && !err;
        // A failed beat breaks the burst: any further SEQ is rejected until a NONSEQ.
        trk_vld  <= !err;
        trk_addr <= nxt_addr;
      end
      if (rd_load) HRDATA <= rd_word;
    end
  end

  // Storage is not reset; reset forces IDLE so a pending write never commits.
  always_ff @(posedge HCLK) begin
    if (wr_now) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be[b]) mem[dp_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end
endmodule
